layer2_maxpool: RTL and testbench
=================================

LAYER2_MAXPOOL -- requirements
Module: layer2_maxpool

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 128: width of one memory word (`LAYER2_OUTPUT_LENGTH).
REQ-002 The block SHALL have parameter LANE_W, default 16: width of one signed channel lane; lanes = DATA_W/LANE_W = 8.
REQ-003 The block SHALL have parameter IN_DIM, default 30: input feature-map rows and columns; output is IN_DIM/2 = 15 per side.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to pool the whole layer-2 result map.
REQ-007 The block SHALL have port layer2_result_read_signal, output, 1 bit: read enable to the layer-2 result memory.
REQ-008 The block SHALL have port read_row_addr, output, 16 bits: layer-2 memory row being read.
REQ-009 The block SHALL have port read_col_addr, output, 16 bits: layer-2 memory column being read.
REQ-010 The block SHALL have port layer2_result_output, input, DATA_W bits: read data, valid combinationally in the same cycle as the address.
REQ-011 The block SHALL have port pool_save_enable, output, 1 bit: write strobe for one pooled word.
REQ-012 The block SHALL have port pool_row_addr, output, 16 bits: pooled row, 0..14.
REQ-013 The block SHALL have port pool_col_addr, output, 16 bits: pooled column, 0..14.
REQ-014 The block SHALL have port pool_data_out, output, DATA_W bits: pooled word.
REQ-015 The block SHALL have port pool_ready, input, 1 bit: the downstream store accepts the write in the current cycle.
REQ-016 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until DONE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse when the last pooled word has been accepted.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and DONE; reset state IDLE.
REQ-019 In IDLE, start=1 SHALL move the FSM to READ with window (pr,pc)=(0,0) and sub-counter k=0; start SHALL be ignored in any other state.
REQ-020 In READ, layer2_result_read_signal SHALL be 1, and the addresses SHALL follow k=0..3 as: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1), one address per cycle.
REQ-021 At k=0 the accumulator SHALL load layer2_result_output; at k=1..3 each 16-bit lane SHALL be replaced by the signed maximum of the accumulator lane and the input lane.
REQ-022 After k=3 the FSM SHALL go to WRITE; read_signal SHALL be 0 and the read addresses SHALL be 0 outside READ.
REQ-023 In WRITE, pool_save_enable SHALL be 1 and pool_row/col_addr=(pr,pc), with pool_data_out holding the accumulator; all three SHALL be held stable while pool_ready=0.
REQ-024 The write SHALL complete in the cycle where WRITE and pool_ready=1; then pc SHALL increment, wrapping to 0 with pr+1 at pc=14.
REQ-025 After the write of (14,14) the FSM SHALL go to DONE, otherwise to READ with k=0.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL be 1 in READ and WRITE only.
REQ-027 The fastest pass SHALL be 225 windows x 5 cycles = 1125 cycles from the first READ cycle to DONE.
REQ-028 pool_save_enable SHALL be 0 whenever the state is not WRITE; pool_data_out SHALL be 0 outside WRITE.
REQ-029 Lane compare SHALL be signed two's complement, no saturation; equal values SHALL leave the lane unchanged.

Reset
REQ-030 While rst=1, state SHALL be IDLE, all counters and the accumulator SHALL be 0, and every output SHALL be 0.
REQ-031 rst asserted mid-pass SHALL abort the pass with no done pulse; a new start after release SHALL restart at window (0,0).

Verification
REQ-032 Map where lane0 of word(r,c) = r*30+c and all other lanes = -(r*30+c); start with pool_ready=1 -> 225 writes, word(pr,pc) lane0 = (2pr+1)*30+2pc+1, other lanes = -(2pr*30+2pc), done exactly 1126 cycles after start.
REQ-033 Window (0,0) lanes {-5,-3,-7,-32768} -> pool word (0,0) lane = -3; all-equal values 100 -> 100.
REQ-034 pool_ready held 0 for 7 cycles at window (3,4) -> pool_save_enable held 1, address (3,4) and data stable, no extra reads, progress resumes on release.
REQ-035 start pulsed again at cycle 50 of a pass -> ignored; write count 225, single done pulse.
REQ-036 rst pulsed at window (7,2) -> all outputs 0 next edge, busy=0; new start -> first read address (0,0).
REQ-037 After the pass, read address coverage SHALL be every (r,c) in 0..29 exactly once, with final pool address (14,14).

Source files
------------

// File: rtl/layer2_maxpool.sv
// rtl/layer2_maxpool.sv - 2x2 signed lane-wise max pooling of the layer-2 result map
// Reads each 2x2 window one word per cycle, then holds the pooled word until the store accepts it.
module layer2_maxpool #(
    parameter int DATA_W = 128,
    parameter int LANE_W = 16,
    parameter int IN_DIM = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              layer2_result_read_signal,
    output logic [15:0]       read_row_addr,
    output logic [15:0]       read_col_addr,
    input  logic [DATA_W-1:0] layer2_result_output,
    output logic              pool_save_enable,
    output logic [15:0]       pool_row_addr,
    output logic [15:0]       pool_col_addr,
    output logic [DATA_W-1:0] pool_data_out,
    input  logic              pool_ready,
    output logic              busy,
    output logic              done
);
    localparam int LANES   = DATA_W / LANE_W;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      pr_q;
    logic [CW-1:0]      pc_q;
    logic [1:0]         k_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  acc_d;
    logic [15:0]        pr_w;
    logic [15:0]        pc_w;

    assign pr_w = 16'(pr_q);
    assign pc_w = 16'(pc_q);

    // k=0 loads the first word of the window; later words only win on strictly greater lanes
    always_comb begin
        acc_d = acc_q;
        for (int l = 0; l < LANES; l++) begin
            if (k_q == 2'd0 ||
                $signed(layer2_result_output[l*LANE_W +: LANE_W]) > $signed(acc_q[l*LANE_W +: LANE_W]))
                acc_d[l*LANE_W +: LANE_W] = layer2_result_output[l*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pr_q    <= '0;
            pc_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_READ;
                        pr_q    <= '0;
                        pc_q    <= '0;
                        k_q     <= '0;
                    end
                end
                S_READ: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3)
                        state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (pool_ready) begin
                        k_q <= '0;
                        if (pc_q == LAST) begin
                            pc_q <= '0;
                            if (pr_q == LAST) begin
                                state_q <= S_DONE;
                            end else begin
                                pr_q    <= pr_q + 1'b1;
                                state_q <= S_READ;
                            end
                        end else begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    pr_q    <= '0;
                    pc_q    <= '0;
                    acc_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only, so nothing glitches on layer2_result_output
    assign layer2_result_read_signal = (state_q == S_READ);
    assign read_row_addr    = (state_q == S_READ) ? ((pr_w << 1) | 16'(k_q[1])) : 16'd0;
    assign read_col_addr    = (state_q == S_READ) ? ((pc_w << 1) | 16'(k_q[0])) : 16'd0;
    assign pool_save_enable = (state_q == S_WRITE);
    assign pool_row_addr    = (state_q == S_WRITE) ? pr_w : 16'd0;
    assign pool_col_addr    = (state_q == S_WRITE) ? pc_w : 16'd0;
    assign pool_data_out    = (state_q == S_WRITE) ? acc_q : '0;
    assign busy             = (state_q == S_READ) || (state_q == S_WRITE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_layer2_maxpool.sv
// tb/tb_layer2_maxpool.sv - scoreboard bench for layer2_maxpool
// Expected pooled words are queued per pass; a negedge monitor pops them on every accepted write.
module tb_layer2_maxpool;
    localparam int DW = 128;
    localparam int LW = 16;
    localparam int ND = 30;
    localparam int OD = 15;

    typedef struct {
        int          r;
        int          c;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rd_sig;
    logic [15:0]   rd_row;
    logic [15:0]   rd_col;
    logic [DW-1:0] rd_data;
    logic          pse;
    logic [15:0]   prow;
    logic [15:0]   pcol;
    logic [DW-1:0] pdata;
    logic          pool_ready = 1'b1;
    logic          busy;
    logic          done_o;

    logic [DW-1:0] mem [0:ND-1][0:ND-1];
    int            cov [0:ND-1][0:ND-1];
    exp_t          exp_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_wr = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, oob = 0;
    int last_r = -1, last_c = -1;
    bit force_stall = 0, rand_mode = 0;

    layer2_maxpool #(.DATA_W(DW), .LANE_W(LW), .IN_DIM(ND)) dut (
        .clk(clk), .rst(rst), .start(start),
        .layer2_result_read_signal(rd_sig),
        .read_row_addr(rd_row), .read_col_addr(rd_col),
        .layer2_result_output(rd_data),
        .pool_save_enable(pse), .pool_row_addr(prow), .pool_col_addr(pcol),
        .pool_data_out(pdata), .pool_ready(pool_ready),
        .busy(busy), .done(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        rd_data = '0;
        if (rd_sig && rd_row < 16'(ND) && rd_col < 16'(ND))
            rd_data = mem[rd_row][rd_col];
    end

    always @(posedge clk) begin
        #1;
        if (force_stall) pool_ready = 1'b0;
        else if (rand_mode) pool_ready = ($urandom_range(0, 3) != 0);
        else pool_ready = 1'b1;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_sig) begin
                if (rd_row < 16'(ND) && rd_col < 16'(ND)) cov[rd_row][rd_col]++;
                else oob++;
            end
            n_cmp++;
            if (!pse && pdata != '0) begin
                n_err++;
                $display("FAIL data_outside_write: got %h expected 0", pdata);
            end
            if (pse && pool_ready) begin
                n_wr++;
                last_r = int'(prow);
                last_c = int'(pcol);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got (%0d,%0d) expected no write", prow, pcol);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(prow) != e.r || int'(pcol) != e.c || pdata !== e.d) begin
                        n_err++;
                        $display("FAIL pool_word: got (%0d,%0d) %h expected (%0d,%0d) %h",
                                 prow, pcol, pdata, e.r, e.c, e.d);
                    end
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (start && !busy && !done_o) start_cyc = cyc;
        end
    end

    function automatic logic [DW-1:0] ref_pool(input int pr, input int pc);
        logic [DW-1:0] res;
        res = '0;
        for (int l = 0; l < DW / LW; l++) begin
            int m;
            m = -100000;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    int v;
                    v = int'($signed(mem[2*pr+dr][2*pc+dc][l*LW +: LW]));
                    if (v > m) m = v;
                end
            res[l*LW +: LW] = 16'(m);
        end
        return res;
    endfunction

    task automatic push_exp(input int pr, input int pc, input logic [DW-1:0] d);
        exp_t e;
        e.r = pr;
        e.c = pc;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_model();
        for (int pr = 0; pr < OD; pr++)
            for (int pc = 0; pc < OD; pc++)
                push_exp(pr, pc, ref_pool(pr, pc));
    endtask

    task automatic fill_cell(input int r, input int c, input int v);
        for (int l = 0; l < DW / LW; l++) mem[r][c][l*LW +: LW] = 16'(v);
    endtask

    task automatic fill_random();
        for (int r = 0; r < ND; r++)
            for (int c = 0; c < ND; c++)
                for (int l = 0; l < DW / LW; l++) mem[r][c][l*LW +: LW] = 16'($urandom);
    endtask

    task automatic clear_cov();
        for (int r = 0; r < ND; r++)
            for (int c = 0; c < ND; c++) cov[r][c] = 0;
        oob = 0;
    endtask

    task automatic check_cov(input string name);
        int bad;
        bad = oob;
        for (int r = 0; r < ND; r++)
            for (int c = 0; c < ND; c++)
                if (cov[r][c] != 1) bad++;
        check(name, DW'(bad), DW'(0));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        if (i == 20000) check(name, DW'(0), DW'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"},   DW'(rd_sig), DW'(0));
        check({tag, "_raddr"}, DW'({rd_row, rd_col}), DW'(0));
        check({tag, "_wr"},   DW'(pse), DW'(0));
        check({tag, "_waddr"}, DW'({prow, pcol}), DW'(0));
        check({tag, "_data"}, pdata, DW'(0));
        check({tag, "_busy"}, DW'(busy), DW'(0));
        check({tag, "_done"}, DW'(done_o), DW'(0));
    endtask

    initial begin
        int d0, w0, i;
        logic [DW-1:0] snap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        #1 rst = 1'b0;

        // Pass A: structured map, store always ready, expectations from the closed form
        for (int r = 0; r < ND; r++)
            for (int c = 0; c < ND; c++) begin
                fill_cell(r, c, -(r * ND + c));
                mem[r][c][LW-1:0] = 16'(r * ND + c);
            end
        for (int pr = 0; pr < OD; pr++)
            for (int pc = 0; pc < OD; pc++) begin
                logic [DW-1:0] d;
                for (int l = 0; l < DW / LW; l++) d[l*LW +: LW] = 16'(-(2*pr*ND + 2*pc));
                d[LW-1:0] = 16'((2*pr+1)*ND + 2*pc + 1);
                push_exp(pr, pc, d);
            end
        clear_cov();
        d0 = done_cnt; w0 = n_wr;
        pulse_start();
        @(negedge clk);
        check("a_busy", DW'(busy), DW'(1));
        wait_done("a_done_timeout", d0);
        check("a_latency", DW'(done_cyc - start_cyc), DW'(1126));
        check("a_writes", DW'(n_wr - w0), DW'(225));
        check("a_last_addr", DW'({16'(last_r), 16'(last_c)}), DW'({16'd14, 16'd14}));
        check_cov("a_coverage");
        check("a_queue_left", DW'(exp_q.size()), DW'(0));
        @(negedge clk);
        check("a_done_pulse", DW'(done_cnt - d0), DW'(1));
        check("a_idle_busy", DW'(busy), DW'(0));

        // Pass B: random map, random backpressure, stall at (3,4), ignored second start
        fill_random();
        fill_cell(0, 0, -5); fill_cell(0, 1, -3); fill_cell(1, 0, -7); fill_cell(1, 1, -32768);
        fill_cell(0, 2, 100); fill_cell(0, 3, 100); fill_cell(1, 2, 100); fill_cell(1, 3, 100);
        push_exp(0, 0, {8{16'hFFFD}});
        push_exp(0, 1, {8{16'd100}});
        for (int pr = 0; pr < OD; pr++)
            for (int pc = 0; pc < OD; pc++)
                if (pr != 0 || pc > 1) push_exp(pr, pc, ref_pool(pr, pc));
        clear_cov();
        rand_mode = 1;
        d0 = done_cnt; w0 = n_wr;
        pulse_start();
        repeat (48) @(posedge clk);
        pulse_start();
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rd_sig && rd_row == 16'd6 && rd_col == 16'd8) break;
        end
        if (i == 5000) check("b_reach_34_timeout", DW'(0), DW'(1));
        force_stall = 1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pse && prow == 16'd3 && pcol == 16'd4) break;
        end
        if (i == 20) check("b_write_34_timeout", DW'(0), DW'(1));
        snap = pdata;
        check("b_stall_data", snap, ref_pool(3, 4));
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            check("b_stall_en", DW'(pse), DW'(1));
            check("b_stall_addr", DW'({prow, pcol}), DW'({16'd3, 16'd4}));
            check("b_stall_hold", pdata, snap);
            check("b_stall_noread", DW'(rd_sig), DW'(0));
        end
        force_stall = 0;
        wait_done("b_done_timeout", d0);
        rand_mode = 0;
        check("b_writes", DW'(n_wr - w0), DW'(225));
        check_cov("b_coverage");
        check("b_queue_left", DW'(exp_q.size()), DW'(0));
        repeat (3) @(negedge clk);
        check("b_done_pulses", DW'(done_cnt - d0), DW'(1));

        // Pass C: reset mid-pass at window (7,2), then a clean restart
        fill_random();
        push_model();
        d0 = done_cnt;
        pulse_start();
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pse && prow == 16'd7 && pcol == 16'd2) break;
        end
        if (i == 5000) check("c_reach_72_timeout", DW'(0), DW'(1));
        rst = 1'b1;
        #1;
        check_idle_outputs("c_async");
        @(posedge clk); #1;
        check_idle_outputs("c_edge");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("c_no_done", DW'(done_cnt - d0), DW'(0));
        fill_random();
        push_model();
        clear_cov();
        d0 = done_cnt; w0 = n_wr;
        pulse_start();
        @(negedge clk);
        check("c_first_read", DW'({15'd0, rd_sig, rd_row, rd_col}), DW'({15'd0, 1'b1, 16'd0, 16'd0}));
        wait_done("c_done_timeout", d0);
        check("c_latency", DW'(done_cyc - start_cyc), DW'(1126));
        check("c_writes", DW'(n_wr - w0), DW'(225));
        check_cov("c_coverage");
        check("c_queue_left", DW'(exp_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
